// File: rtl/delta_adc_multich.sv
// delta_adc_multich: round-robin multichannel tracking delta ADC with adaptive step size
// and per-channel PWM DAC outputs whose duties reload only on PWM period boundaries.
module delta_adc_multich #(
    parameter int W             = 16,
    parameter int NCH           = 4,
    parameter int STROBE_CYCLES = 16,
    parameter int MAX_SHIFT     = 4,
    parameter int RUN_LEN       = 3,
    localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [W-1:0]      period_counter_val,
    input  logic [NCH-1:0]    comparator_i,
    output logic [NCH*W-1:0]  on_counter_vals,
    output logic              adc_valid_strb,
    output logic [CW-1:0]     adc_ch,
    output logic [W-1:0]      adc_value,
    output logic [NCH-1:0]    overload,
    output logic [NCH-1:0]    pwm_o
);

    localparam int SHW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
    localparam int RW  = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam int STW = $clog2(STROBE_CYCLES);
    localparam logic [W:0] VMAX = {1'b0, {W{1'b1}}};

    logic [NCH-1:0]  sync1_r;
    logic [NCH-1:0]  sync2_r;
    logic [STW-1:0]  strb_cnt_r;
    logic [CW-1:0]   ptr_r;
    logic [W-1:0]    value_r    [NCH];
    logic [SHW-1:0]  shift_r    [NCH];
    logic [RW-1:0]   run_r      [NCH];
    logic [NCH-1:0]  last_dir_r;

    logic [W-1:0]    shadow_r   [NCH];
    logic [W-1:0]    pwm_cnt_r;
    logic [W-1:0]    period_r;

    logic            strobe_s;
    logic            dir_s;
    logic [W-1:0]    old_val_s;
    logic [SHW-1:0]  old_shift_s;
    logic [RW-1:0]   old_run_s;
    logic [W:0]      step_s;
    logic [W:0]      wide_s;
    logic [W-1:0]    new_val_s;
    logic [SHW-1:0]  new_shift_s;
    logic [RW-1:0]   new_run_s;
    logic            new_ovl_s;

    logic            wrap_s;
    logic [W-1:0]    pwm_cnt_nxt_s;
    logic [W-1:0]    period_nxt_s;
    logic [W-1:0]    shadow_nxt_s [NCH];
    logic [NCH-1:0]  pwm_nxt_s;

    assign strobe_s = enable_i && (strb_cnt_r == STW'(STROBE_CYCLES - 1));

    // Next value, step exponent and run length for the channel under the pointer
    always_comb begin
        old_val_s   = value_r[ptr_r];
        old_shift_s = shift_r[ptr_r];
        old_run_s   = run_r[ptr_r];
        dir_s       = sync2_r[ptr_r];
        step_s      = {{W{1'b0}}, 1'b1} << old_shift_s;
        new_val_s   = old_val_s;
        new_shift_s = old_shift_s;
        new_run_s   = old_run_s;
        // Arithmetic is one bit wider than the value so both rails clamp instead of wrapping
        if (dir_s) begin
            wide_s = {1'b0, old_val_s} + step_s;
            if (wide_s > VMAX) begin
                new_val_s = {W{1'b1}};
            end else begin
                new_val_s = wide_s[W-1:0];
            end
        end else begin
            wide_s = {1'b0, old_val_s} - step_s;
            if (wide_s[W]) begin
                new_val_s = {W{1'b0}};
            end else begin
                new_val_s = wide_s[W-1:0];
            end
        end
        if (dir_s == last_dir_r[ptr_r]) begin
            if (old_run_s == RW'(RUN_LEN - 1)) begin
                new_run_s = {RW{1'b0}};
                if (old_shift_s == SHW'(MAX_SHIFT)) begin
                    new_shift_s = old_shift_s;
                end else begin
                    new_shift_s = old_shift_s + SHW'(1);
                end
            end else begin
                new_run_s   = old_run_s + RW'(1);
                new_shift_s = old_shift_s;
            end
        end else begin
            new_run_s = {RW{1'b0}};
            if (old_shift_s == {SHW{1'b0}}) begin
                new_shift_s = old_shift_s;
            end else begin
                new_shift_s = old_shift_s - SHW'(1);
            end
        end
        new_ovl_s = (new_shift_s == SHW'(MAX_SHIFT)) || (new_val_s == {W{1'b0}})
                    || (new_val_s == {W{1'b1}});
    end

    // Synchroniser, strobe timing, round-robin service and result reporting
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r        <= {NCH{1'b0}};
            sync2_r        <= {NCH{1'b0}};
            strb_cnt_r     <= {STW{1'b0}};
            ptr_r          <= {CW{1'b0}};
            last_dir_r     <= {NCH{1'b0}};
            overload       <= {NCH{1'b0}};
            adc_valid_strb <= 1'b0;
            adc_ch         <= {CW{1'b0}};
            adc_value      <= {W{1'b0}};
            for (int c = 0; c < NCH; c++) begin
                value_r[c] <= {1'b1, {(W-1){1'b0}}};
                shift_r[c] <= {SHW{1'b0}};
                run_r[c]   <= {RW{1'b0}};
            end
        end else begin
            sync1_r <= comparator_i;
            sync2_r <= sync1_r;
            if (enable_i) begin
                if (strobe_s) begin
                    strb_cnt_r <= {STW{1'b0}};
                end else begin
                    strb_cnt_r <= strb_cnt_r + STW'(1);
                end
            end else begin
                strb_cnt_r <= strb_cnt_r;
            end
            if (strobe_s) begin
                value_r[ptr_r]    <= new_val_s;
                shift_r[ptr_r]    <= new_shift_s;
                run_r[ptr_r]      <= new_run_s;
                last_dir_r[ptr_r] <= dir_s;
                overload[ptr_r]   <= new_ovl_s;
                adc_valid_strb    <= (new_val_s != old_val_s);
                if (new_val_s != old_val_s) begin
                    adc_ch    <= ptr_r;
                    adc_value <= new_val_s;
                end else begin
                    adc_ch    <= adc_ch;
                    adc_value <= adc_value;
                end
                if (ptr_r == CW'(NCH - 1)) begin
                    ptr_r <= {CW{1'b0}};
                end else begin
                    ptr_r <= ptr_r + CW'(1);
                end
            end else begin
                adc_valid_strb <= 1'b0;
            end
        end
    end

    // PWM next state; pwm_o is registered from the next counter and shadow so it matches them exactly
    always_comb begin
        wrap_s = (period_r == {W{1'b0}}) || (pwm_cnt_r == period_r - W'(1));
        if (wrap_s) begin
            pwm_cnt_nxt_s = {W{1'b0}};
            period_nxt_s  = period_counter_val;
        end else begin
            pwm_cnt_nxt_s = pwm_cnt_r + W'(1);
            period_nxt_s  = period_r;
        end
        for (int c = 0; c < NCH; c++) begin
            if (wrap_s) begin
                shadow_nxt_s[c] = value_r[c];
            end else begin
                shadow_nxt_s[c] = shadow_r[c];
            end
            pwm_nxt_s[c] = (period_nxt_s != {W{1'b0}}) && (pwm_cnt_nxt_s < shadow_nxt_s[c]);
        end
    end

    // PWM counter, latched period, shadow duties and outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_r <= {W{1'b0}};
            period_r  <= {W{1'b0}};
            pwm_o     <= {NCH{1'b0}};
            for (int c = 0; c < NCH; c++) begin
                shadow_r[c] <= {W{1'b0}};
            end
        end else begin
            pwm_cnt_r <= pwm_cnt_nxt_s;
            period_r  <= period_nxt_s;
            pwm_o     <= pwm_nxt_s;
            for (int c = 0; c < NCH; c++) begin
                shadow_r[c] <= shadow_nxt_s[c];
            end
        end
    end

    // Flatten the live channel values onto the output bus
    always_comb begin
        on_counter_vals = {(NCH*W){1'b0}};
        for (int c = 0; c < NCH; c++) begin
            on_counter_vals[c*W +: W] = value_r[c];
        end
    end

endmodule

// File: tb/tb_delta_adc_multich.sv
// Self-checking bench for delta_adc_multich: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the channel and PWM rules.
module tb_delta_adc_multich;

    localparam int W    = 8;
    localparam int NCH  = 2;
    localparam int SC   = 4;
    localparam int MS   = 3;
    localparam int RL   = 2;
    localparam int CW   = 1;
    localparam int VMAX = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [W-1:0]     period;
    logic [NCH-1:0]   comp;
    logic [NCH*W-1:0] on_counter_vals;
    logic             adc_valid_strb;
    logic [CW-1:0]    adc_ch;
    logic [W-1:0]     adc_value;
    logic [NCH-1:0]   overload;
    logic [NCH-1:0]   pwm_o;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int m_val[NCH], m_shift[NCH], m_run[NCH], m_shadow[NCH];
    bit m_last[NCH], m_s1[NCH], m_s2[NCH], m_ovl[NCH], m_pwm[NCH];
    int m_scnt, m_ptr, m_pcnt, m_per, m_ch, m_adcv;
    bit m_valid;

    always #5 clk = ~clk;

    delta_adc_multich #(.W(W), .NCH(NCH), .STROBE_CYCLES(SC), .MAX_SHIFT(MS), .RUN_LEN(RL)) dut (
        .clk(clk), .reset(reset_n), .enable_i(enable), .period_counter_val(period),
        .comparator_i(comp), .on_counter_vals(on_counter_vals), .adc_valid_strb(adc_valid_strb),
        .adc_ch(adc_ch), .adc_value(adc_value), .overload(overload), .pwm_o(pwm_o));

    task automatic model_update();
        bit strobe, dir;
        int c, old, nv;
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_val[i] = 1 << (W - 1); m_shift[i] = 0; m_run[i] = 0; m_last[i] = 0;
                m_shadow[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_ovl[i] = 0; m_pwm[i] = 0;
            end
            m_scnt = 0; m_ptr = 0; m_pcnt = 0; m_per = 0; m_valid = 0; m_ch = 0; m_adcv = 0;
        end else begin
            strobe = enable && (m_scnt == SC - 1);
            if (enable) m_scnt = strobe ? 0 : m_scnt + 1;
            dir = m_s2[m_ptr];
            for (int i = 0; i < NCH; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = comp[i];
            end
            if (m_per == 0 || m_pcnt == m_per - 1) begin
                m_pcnt = 0;
                m_per  = int'(period);
                for (int i = 0; i < NCH; i++) m_shadow[i] = m_val[i];
            end else begin
                m_pcnt++;
            end
            m_valid = 0;
            if (strobe) begin
                c   = m_ptr;
                old = m_val[c];
                nv  = dir ? old + (1 << m_shift[c]) : old - (1 << m_shift[c]);
                if (nv > VMAX) nv = VMAX;
                if (nv < 0) nv = 0;
                if (dir == m_last[c]) begin
                    if (m_run[c] == RL - 1) begin
                        m_run[c] = 0;
                        if (m_shift[c] < MS) m_shift[c]++;
                    end else begin
                        m_run[c]++;
                    end
                end else begin
                    m_run[c] = 0;
                    if (m_shift[c] > 0) m_shift[c]--;
                    m_last[c] = dir;
                end
                m_val[c] = nv;
                m_ovl[c] = (m_shift[c] == MS) || (nv == 0) || (nv == VMAX);
                if (nv != old) begin
                    m_valid = 1; m_ch = c; m_adcv = nv;
                end
                m_ptr = (m_ptr + 1) % NCH;
            end
            for (int i = 0; i < NCH; i++) m_pwm[i] = (m_per != 0) && (m_pcnt < m_shadow[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [NCH*W-1:0] m_pack();
        logic [NCH*W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*W +: W] = W'(m_val[i]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_vec_ovl();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_ovl[i];
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_vec_pwm();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_pwm[i];
        return r;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; comp = 2'b00; period = 8'd20;
        tick(); tick();
        n_tests++; if (on_counter_vals !== 16'h8080) begin n_fail++; $display("FAIL reset_vals: got %h want 8080", on_counter_vals); end
        n_tests++; if (pwm_o !== 2'b00) begin n_fail++; $display("FAIL reset_pwm: got %b want 00", pwm_o); end
        n_tests++; if (overload !== 2'b00) begin n_fail++; $display("FAIL reset_ovl: got %b want 00", overload); end
        n_tests++; if (adc_valid_strb !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", adc_valid_strb); end
        n_tests++; if (adc_ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", adc_ch); end
        n_tests++; if (adc_value !== 8'h00) begin n_fail++; $display("FAIL reset_value: got %h want 00", adc_value); end
    endtask

    task automatic test_strobe_order();
        int cyc = 0, k = 0;
        int exp_cyc[3] = '{4, 8, 12};
        int exp_ch[3]  = '{0, 1, 0};
        reset_n = 1'b1;
        while (k < 3 && cyc < 40) begin
            tick(); cyc++;
            if (adc_valid_strb === 1'b1) begin
                n_tests++; if (cyc != exp_cyc[k]) begin n_fail++; $display("FAIL strobe_cycle: pulse %0d at cycle %0d want %0d", k, cyc, exp_cyc[k]); end
                n_tests++; if (adc_ch !== CW'(exp_ch[k])) begin n_fail++; $display("FAIL strobe_ch: pulse %0d ch %0d want %0d", k, adc_ch, exp_ch[k]); end
                k++;
            end
        end
        n_tests++; if (k != 3) begin n_fail++; $display("FAIL strobe_timeout: saw %0d pulses want 3", k); end
    endtask

    task automatic test_ramp();
        int exp_v[9] = '{129, 130, 131, 133, 135, 139, 143, 151, 159};
        int k = 0;
        comp = 2'b01; reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 200 && k < 9; i++) begin
            tick();
            if (adc_valid_strb === 1'b1 && adc_ch === 1'b0) begin
                n_tests++; if (adc_value !== W'(exp_v[k])) begin n_fail++; $display("FAIL ramp_value: svc %0d got %0d want %0d", k + 1, adc_value, exp_v[k]); end
                n_tests++; if (on_counter_vals[W-1:0] !== W'(exp_v[k])) begin n_fail++; $display("FAIL ramp_live: svc %0d got %0d want %0d", k + 1, on_counter_vals[W-1:0], exp_v[k]); end
                n_tests++; if (overload[0] !== (k >= 6)) begin n_fail++; $display("FAIL ramp_ovl: svc %0d got %b want %b", k + 1, overload[0], k >= 6); end
                k++;
            end
        end
        n_tests++; if (k != 9) begin n_fail++; $display("FAIL ramp_timeout: saw %0d ch0 pulses want 9", k); end
    endtask

    task automatic test_reverse();
        int exp_v[3] = '{151, 147, 143};
        bit exp_o[3] = '{1'b0, 1'b0, 1'b1};
        int k = 0;
        comp = 2'b00;
        for (int i = 0; i < 100 && k < 3; i++) begin
            tick();
            if (adc_valid_strb === 1'b1 && adc_ch === 1'b0) begin
                n_tests++; if (adc_value !== W'(exp_v[k])) begin n_fail++; $display("FAIL reverse_value: svc %0d got %0d want %0d", k, adc_value, exp_v[k]); end
                n_tests++; if (overload[0] !== exp_o[k]) begin n_fail++; $display("FAIL reverse_ovl: svc %0d got %b want %b", k, overload[0], exp_o[k]); end
                k++;
            end
        end
        n_tests++; if (k != 3) begin n_fail++; $display("FAIL reverse_timeout: saw %0d pulses want 3", k); end
    endtask

    task automatic test_clamp();
        int bad = 0, ch1_pulses = 0, dut_ch0 = 0, mdl_ch0 = 0;
        bit reached = 0;
        comp = 2'b00;
        for (int i = 0; i < 800 && !reached; i++) begin
            tick();
            n_tests++; if (on_counter_vals !== m_pack()) begin n_fail++; $display("FAIL clamp_track: got %h want %h", on_counter_vals, m_pack()); end
            if (m_val[1] == 0) reached = 1;
        end
        n_tests++; if (!reached) begin n_fail++; $display("FAIL clamp_timeout: ch1 model %0d want 0", m_val[1]); end
        n_tests++; if (on_counter_vals[2*W-1:W] !== 8'h00) begin n_fail++; $display("FAIL clamp_zero: got %0d want 0", on_counter_vals[2*W-1:W]); end
        n_tests++; if (overload[1] !== 1'b1) begin n_fail++; $display("FAIL clamp_ovl: got %b want 1", overload[1]); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (on_counter_vals[2*W-1:W] !== 8'h00) bad++;
            if (adc_valid_strb === 1'b1 && adc_ch === 1'b1) ch1_pulses++;
            if (adc_valid_strb === 1'b1 && adc_ch === 1'b0) dut_ch0++;
            if (m_valid && m_ch == 0) mdl_ch0++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL clamp_hold: %0d cycles off zero, want 0", bad); end
        n_tests++; if (ch1_pulses != 0) begin n_fail++; $display("FAIL clamp_nopulse: got %0d ch1 pulses want 0", ch1_pulses); end
        n_tests++; if (dut_ch0 != mdl_ch0 || mdl_ch0 == 0) begin n_fail++; $display("FAIL clamp_ch0: got %0d ch0 pulses want %0d", dut_ch0, mdl_ch0); end
    endtask

    task automatic test_pwm();
        int highs, i;
        bit seen = 0;
        comp = 2'b10;
        for (i = 0; i < 40 && !seen; i++) begin
            tick();
            if (adc_valid_strb === 1'b1 && adc_ch === 1'b1) seen = 1;
        end
        enable = 1'b0; period = 8'd16;
        n_tests++; if (!seen || adc_value !== 8'd8) begin n_fail++; $display("FAIL pwm_setup: seen %0d value %0d want 8", seen, adc_value); end
        for (i = 0; i < 300 && !(m_per == 16 && m_pcnt == 0); i++) tick();
        n_tests++; if (i >= 300) begin n_fail++; $display("FAIL pwm_wrap_timeout: period %0d want 16", m_per); end
        highs = 0;
        for (i = 0; i < 16; i++) begin highs += int'(pwm_o[1]); tick(); end
        n_tests++; if (highs != 8) begin n_fail++; $display("FAIL pwm_duty8: high %0d of 16 want 8", highs); end
        enable = 1'b1; highs = 0; seen = 0;
        for (i = 0; i < 16; i++) begin
            highs += int'(pwm_o[1]);
            tick();
            if (!seen && adc_valid_strb === 1'b1 && adc_ch === 1'b1) begin
                seen = 1; enable = 1'b0;
                n_tests++; if (adc_value !== 8'd12) begin n_fail++; $display("FAIL pwm_newduty: got %0d want 12", adc_value); end
            end
        end
        enable = 1'b0;
        n_tests++; if (!seen || highs != 8) begin n_fail++; $display("FAIL pwm_midchange: seen %0d high %0d want 8", seen, highs); end
        highs = 0;
        for (i = 0; i < 16; i++) begin highs += int'(pwm_o[1]); tick(); end
        n_tests++; if (highs != 12) begin n_fail++; $display("FAIL pwm_duty12: high %0d of 16 want 12", highs); end
        period = 8'd0;
        for (i = 0; i < 40 && m_per != 0; i++) tick();
        highs = 0;
        for (i = 0; i < 20; i++) begin tick(); if (pwm_o !== 2'b00) highs++; end
        n_tests++; if (highs != 0) begin n_fail++; $display("FAIL pwm_zero_period: %0d cycles high want 0", highs); end
        period = 8'd16;
    endtask

    task automatic test_freeze();
        logic [NCH*W-1:0] frozen;
        int pulses = 0, bad = 0, toggles = 0, i;
        logic prev;
        enable = 1'b0;
        for (i = 0; i < 40 && m_per != 16; i++) tick();
        frozen = m_pack();
        prev = pwm_o[1];
        for (i = 0; i < 20; i++) begin
            comp = 2'($urandom);
            tick();
            if (adc_valid_strb !== 1'b0) pulses++;
            if (on_counter_vals !== frozen) bad++;
            if (pwm_o[1] !== prev) toggles++;
            prev = pwm_o[1];
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL freeze_pulses: got %0d want 0", pulses); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL freeze_vals: %0d cycles changed want 0", bad); end
        n_tests++; if (toggles < 2) begin n_fail++; $display("FAIL freeze_pwm: got %0d toggles want >=2", toggles); end
    endtask

    task automatic test_reset_strobe();
        int i;
        enable = 1'b1;
        for (i = 0; i < 10 && m_scnt != SC - 1; i++) tick();
        reset_n = 1'b0;
        tick();
        n_tests++; if (on_counter_vals !== 16'h8080) begin n_fail++; $display("FAIL rststrb_vals: got %h want 8080", on_counter_vals); end
        n_tests++; if (adc_valid_strb !== 1'b0) begin n_fail++; $display("FAIL rststrb_valid: got %b want 0", adc_valid_strb); end
        n_tests++; if (overload !== 2'b00 || pwm_o !== 2'b00) begin n_fail++; $display("FAIL rststrb_outs: ovl %b pwm %b want 00", overload, pwm_o); end
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) comp = 2'($urandom);
            enable  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 24));
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
            n_tests += 6;
            if (on_counter_vals !== m_pack()) begin n_fail++; if (n_fail < 40) $display("FAIL rnd_vals: cyc %0d got %h want %h", i, on_counter_vals, m_pack()); end
            if (adc_valid_strb !== m_valid) begin n_fail++; if (n_fail < 40) $display("FAIL rnd_valid: cyc %0d got %b want %b", i, adc_valid_strb, m_valid); end
            if (adc_ch !== CW'(m_ch)) begin n_fail++; if (n_fail < 40) $display("FAIL rnd_ch: cyc %0d got %0d want %0d", i, adc_ch, m_ch); end
            if (adc_value !== W'(m_adcv)) begin n_fail++; if (n_fail < 40) $display("FAIL rnd_value: cyc %0d got %0d want %0d", i, adc_value, m_adcv); end
            if (overload !== m_vec_ovl()) begin n_fail++; if (n_fail < 40) $display("FAIL rnd_ovl: cyc %0d got %b want %b", i, overload, m_vec_ovl()); end
            if (pwm_o !== m_vec_pwm()) begin n_fail++; if (n_fail < 40) $display("FAIL rnd_pwm: cyc %0d got %b want %b", i, pwm_o, m_vec_pwm()); end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; comp = 2'b00; period = 8'd20;
        test_reset();
        test_strobe_order();
        test_ramp();
        test_reverse();
        test_clamp();
        test_pwm();
        test_freeze();
        test_reset_strobe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
